// File: rtl/counter_pkg.sv
// Shared encodings and elaboration-time helpers for the modulo counter family.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  function automatic bit params_ok(input int width, input int max, input int prescale,
                                   input int saturate);
    longint unsigned top;
    top = (longint'(1) << width) - 1;
    return (width >= 1) && (max >= 1) && (longint'(max) <= top) && (prescale >= 1) &&
           ((saturate == CNT_WRAP) || (saturate == CNT_SAT));
  endfunction

  function automatic int prescale_bits(input int prescale);
    return (prescale > 2) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
interface updown_mod_counter_if #(
  parameter int WIDTH = 8
);
  logic             En;
  logic             Up;
  logic             Load;
  logic [WIDTH-1:0] LoadValue;
  logic [WIDTH-1:0] Count;
  logic             Tc;

  modport master (output En, Up, Load, LoadValue, input Count, Tc);
  modport slave  (input En, Up, Load, LoadValue, output Count, Tc);
endinterface

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE; Tick is a combinational step strobe.
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic Clear,
  input  logic En,
  output logic Tick
);

  if (PRESCALE == 1) begin : g_bypass
    logic unused_inputs;
    assign unused_inputs = ^{Clock, Resetn, Clear};
    assign Tick = En;
  end else begin : g_div
    localparam int PW = prescale_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge Clock) begin
      if (!Resetn || Clear) begin
        cnt <= '0;
      end else if (En) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end

    assign Tick = En && (cnt == LAST);
  end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with load, wrap-or-saturate bounds and registered Tc pulse.
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX      = 255,
  parameter int PRESCALE = 1,
  parameter int SATURATE = CNT_WRAP
) (
  input logic                  Clock,
  input logic                  Resetn,
  updown_mod_counter_if.slave  bus
);

  if (!params_ok(WIDTH, MAX, PRESCALE, SATURATE)) begin : g_bad_params
    $error("updown_mod_counter: illegal WIDTH/MAX/PRESCALE/SATURATE combination");
  end

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic             step;
  logic             at_bound;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] load_sat;
  logic             tc_q;
  logic             tc_d;

  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Clear  (bus.Load),
    .En     (bus.En),
    .Tick   (step)
  );

  assign at_bound = bus.Up ? (count_q == MAX_V) : (count_q == '0);
  assign load_sat = (bus.LoadValue > MAX_V) ? MAX_V : bus.LoadValue;

  // Load outranks a coincident step, so no Tc is produced on a load cycle.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.Load) begin
      count_d = load_sat;
    end else if (step) begin
      tc_d = at_bound;
      if (!at_bound) begin
        count_d = bus.Up ? count_q + 1'b1 : count_q - 1'b1;
      end else if (SATURATE == CNT_WRAP) begin
        count_d = bus.Up ? '0 : MAX_V;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.Count = count_q;
  assign bus.Tc    = tc_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: wrap, saturate and prescaled instances.
module tb_updown_mod_counter;
  import counter_pkg::*;

  logic Clock;
  logic rst_a, rst_s, rst_p;
  int   n_checks = 0;
  int   n_fail   = 0;

  updown_mod_counter_if #(.WIDTH(4)) if_a ();
  updown_mod_counter_if #(.WIDTH(4)) if_s ();
  updown_mod_counter_if #(.WIDTH(4)) if_p ();

  updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(CNT_WRAP)) dut_a (
    .Clock(Clock), .Resetn(rst_a), .bus(if_a.slave));
  updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(1), .SATURATE(CNT_SAT)) dut_s (
    .Clock(Clock), .Resetn(rst_s), .bus(if_s.slave));
  updown_mod_counter #(.WIDTH(4), .MAX(9), .PRESCALE(3), .SATURATE(CNT_WRAP)) dut_p (
    .Clock(Clock), .Resetn(rst_p), .bus(if_p.slave));

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  typedef struct {
    logic       rstn;
    logic       en;
    logic       up;
    logic       load;
    logic [3:0] lv;
    logic [3:0] exp_c;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rstn, input logic en, input logic up,
                              input logic load, input logic [3:0] lv,
                              input logic [3:0] exp_c, input logic exp_tc);
    vec_t v;
    v.rstn = rstn; v.en = en; v.up = up; v.load = load; v.lv = lv;
    v.exp_c = exp_c; v.exp_tc = exp_tc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive_s(input logic rstn, input logic en, input logic up,
                         input logic load, input logic [3:0] lv);
    rst_s = rstn; if_s.En = en; if_s.Up = up; if_s.Load = load; if_s.LoadValue = lv;
  endtask

  task automatic drive_p(input logic rstn, input logic en, input logic up,
                         input logic load, input logic [3:0] lv);
    rst_p = rstn; if_p.En = en; if_p.Up = up; if_p.Load = load; if_p.LoadValue = lv;
  endtask

  task automatic expect_s(input string name, input logic [3:0] c, input logic tc);
    check({name, ".count"}, 8'(if_s.Count), 8'(c));
    check({name, ".tc"}, 8'(if_s.Tc), 8'(tc));
  endtask

  task automatic expect_p(input string name, input logic [3:0] c, input logic tc);
    check({name, ".count"}, 8'(if_p.Count), 8'(c));
    check({name, ".tc"}, 8'(if_p.Tc), 8'(tc));
  endtask

  initial begin
    logic [3:0] exp_seq[7];
    rst_a = 1'b0; if_a.En = 1'b0; if_a.Up = 1'b1; if_a.Load = 1'b0; if_a.LoadValue = '0;
    drive_s(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    drive_p(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Wrap instance: count up through the modulus, then down from reset.
    add(0, 1, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 12; i++) begin
      add(1, 1, 1, 0, 0, 4'((i % 10)), (i == 10));
    end
    add(0, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 9, 1);
    add(1, 1, 0, 0, 0, 8, 0);
    add(1, 1, 0, 0, 0, 7, 0);
    add(1, 0, 0, 0, 0, 7, 0);
    add(1, 0, 1, 1, 12, 9, 0);
    add(1, 1, 1, 1, 3, 3, 0);
    add(1, 1, 1, 0, 0, 4, 0);
    add(1, 1, 0, 0, 0, 3, 0);
    add(1, 0, 1, 1, 15, 9, 0);
    add(1, 1, 1, 1, 9, 9, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rstn; if_a.En = vecs[i].en; if_a.Up = vecs[i].up;
      if_a.Load = vecs[i].load; if_a.LoadValue = vecs[i].lv;
      tick();
      check($sformatf("vec%0d.count", i), 8'(if_a.Count), 8'(vecs[i].exp_c));
      check($sformatf("vec%0d.tc", i), 8'(if_a.Tc), 8'(vecs[i].exp_tc));
    end
    if_a.En = 1'b0;

    // Saturate instance: hold at MAX going up, hold at 0 going down.
    tick();
    expect_s("sat.reset", 0, 0);
    drive_s(1, 0, 1, 1, 4'd8); tick(); expect_s("sat.load8", 8, 0);
    drive_s(1, 1, 1, 0, 4'd0); tick(); expect_s("sat.up1", 9, 0);
    tick(); expect_s("sat.up2", 9, 1);
    tick(); expect_s("sat.up3", 9, 1);
    drive_s(1, 0, 1, 0, 4'd0); tick(); expect_s("sat.idle", 9, 0);
    drive_s(0, 1, 0, 0, 4'd0); tick(); expect_s("sat.reset2", 0, 0);
    drive_s(1, 1, 0, 0, 4'd0); tick(); expect_s("sat.dn1", 0, 1);
    tick(); expect_s("sat.dn2", 0, 1);
    drive_s(1, 1, 1, 0, 4'd0); tick(); expect_s("sat.turn", 1, 0);

    // Prescaled instance: one step per three enabled cycles.
    tick();
    expect_p("pre.reset", 0, 0);
    exp_seq = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    drive_p(1, 1, 1, 0, 4'd0);
    for (int i = 0; i < 7; i++) begin
      tick();
      expect_p($sformatf("pre.edge%0d", i + 1), exp_seq[i], 0);
    end
    drive_p(1, 0, 1, 0, 4'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_p($sformatf("pre.hold%0d", i), 2, 0);
    end
    drive_p(1, 1, 1, 0, 4'd0); tick(); expect_p("pre.resume1", 2, 0);
    tick(); expect_p("pre.resume2", 3, 0);

    // Load mid-period discards the partial prescale count.
    tick(); expect_p("pre.mid", 3, 0);
    drive_p(1, 1, 1, 1, 4'd7); tick(); expect_p("pre.load7", 7, 0);
    drive_p(1, 1, 1, 0, 4'd0); tick(); expect_p("pre.ld_a", 7, 0);
    tick(); expect_p("pre.ld_b", 7, 0);
    tick(); expect_p("pre.ld_c", 8, 0);

    // Reset mid-period with Count=5.
    drive_p(1, 0, 1, 1, 4'd5); tick(); expect_p("pre.load5", 5, 0);
    drive_p(1, 1, 1, 0, 4'd0); tick(); expect_p("pre.part", 5, 0);
    drive_p(0, 1, 1, 0, 4'd0); tick(); expect_p("pre.rst", 0, 0);
    drive_p(1, 1, 1, 0, 4'd0); tick(); expect_p("pre.rel1", 0, 0);
    tick(); expect_p("pre.rel2", 0, 0);
    tick(); expect_p("pre.rel3", 1, 0);

    // Prescaled down-wrap from 0 produces Tc on the step edge only.
    tick(); tick();
    drive_p(1, 1, 0, 1, 4'd0); tick(); expect_p("pre.load0", 0, 0);
    drive_p(1, 1, 0, 0, 4'd0); tick(); tick(); expect_p("pre.dn_wait", 0, 0);
    tick(); expect_p("pre.dn_wrap", 9, 1);
    tick(); expect_p("pre.dn_after", 9, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
